// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the FIFO stream reader.
//   FIFO_WIDTH  : default data word width
//   RD_LAT      : FIFO read latency in cycles (o_rden -> i_rddata)
//   rdr_state_t : reader FSM states (IDLE, STREAM, FULL)
//   state_of()  : maps buffer occupancy and in-flight flag to an FSM state
package fifo_pkg;

    localparam int FIFO_WIDTH = 128;
    localparam int RD_LAT     = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FULL   = 2'd2
    } rdr_state_t;

    function automatic rdr_state_t state_of(input logic [1:0] occ, input logic pend);
        rdr_state_t s;
        if (occ == 2'd2)
            s = FULL;
        else if (occ != 2'd0 || pend)
            s = STREAM;
        else
            s = IDLE;
        return s;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf -- 2-entry in-order buffer holding words returned by the FIFO
// until the stream consumer takes them.
// Ports:
//   clk   : clock
//   rstn  : synchronous active-high reset (clears contents and occupancy)
//   clear : synchronous discard of all buffered words (contents kept, occ -> 0)
//   push  : write din at the tail
//   pop   : drop the head entry
//   din   : word to write
//   dout  : head entry
//   occ   : number of valid entries, 0..2
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    // ent0 is always the head; ent1 only holds data when occ == 2
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;

    always_ff @(posedge clk) begin
        if (rstn) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else if (clear) begin
            occ  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged: head advances, new word lands at tail
                    if (occ == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = ent0;

    // The read gating upstream must never let a word arrive into a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (rstn || clear)
        !(push && !pop && occ == 2'd2));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader -- pulls words from a 1-cycle-latency FIFO and presents
// them as a valid/ready stream at up to one word per cycle.
// Optional feature: define FIFO_RDR_XFER_CNT_EN to add o_xfer_cnt, a wrapping
// count of accepted stream words (cleared only by reset).
// Ports:
//   clk        : clock
//   rstn       : synchronous active-high reset
//   i_en       : read enable (buffered words still drain when low)
//   i_flush    : discard buffered and in-flight words
//   i_empty    : FIFO empty flag
//   i_rddata   : FIFO read data, valid one cycle after o_rden
//   o_rden     : FIFO read strobe
//   o_valid    : stream word available
//   i_ready    : stream consumer accepts the word
//   o_data     : stream word (head of buffer)
//   o_xfer_cnt : accepted-word counter (only with FIFO_RDR_XFER_CNT_EN)
//   o_busy     : reader not IDLE
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_rddata,
    output logic             o_rden,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
`ifdef FIFO_RDR_XFER_CNT_EN
    output logic [CNT_W-1:0] o_xfer_cnt,
`endif
    output logic             o_busy
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("reader pipeline is built for a read latency of 1");
    end

    logic [1:0] occ;
    logic [1:0] occ_nxt;
    logic       pend;
    logic       pop;
    logic       push;
    logic [2:0] room;
    rdr_state_t state;
    rdr_state_t state_nxt;

    assign o_valid = (occ != 2'd0);
    assign pop     = o_valid && i_ready;
    assign push    = pend;

    // Slots committed after this cycle: buffered + in flight - leaving now.
    // pop implies occ >= 1, so this never underflows.
    assign room   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign o_rden = i_en && !i_empty && !i_flush && !rstn && (room < 3'd2);

    fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .clear (i_flush),
        .push  (push),
        .pop   (pop),
        .din   (i_rddata),
        .dout  (o_data),
        .occ   (occ)
    );

    // In-flight flag: the word strobed this cycle is on i_rddata next cycle
    always_ff @(posedge clk) begin
        if (rstn || i_flush) pend <= 1'b0;
        else                 pend <= o_rden;
    end

    // FSM tracks the occupancy/in-flight pair the buffer will hold next cycle
    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        occ_nxt   = occ;
        state_nxt = state;
        if (i_flush)
            occ_nxt = 2'd0;
        else
            occ_nxt = occ + {1'b0, push} - {1'b0, pop};
        state_nxt = state_of(occ_nxt, o_rden);
    end

    assign o_busy = (state != IDLE);

`ifdef FIFO_RDR_XFER_CNT_EN
    logic [CNT_W-1:0] xfer_cnt;

    always_ff @(posedge clk) begin
        if (rstn)     xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign o_xfer_cnt = xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader -- randomized and directed checks of fifo_stream_reader
// against a queue-based model: a FIFO queue feeds a scoreboard of words that
// have been read, each tagged with the cycle it becomes visible on the stream.
module tb_fifo_stream_reader;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic         clk;
    logic         rstn;
    logic         i_en;
    logic         i_flush;
    logic         i_empty;
    logic [W-1:0] i_rddata;
    logic         o_rden;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         o_busy;
`ifdef FIFO_RDR_XFER_CNT_EN
    logic [CNT_W-1:0] o_xfer_cnt;
`endif

    fifo_stream_reader #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (i_en),
        .i_flush    (i_flush),
        .i_empty    (i_empty),
        .i_rddata   (i_rddata),
        .o_rden     (o_rden),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
`ifdef FIFO_RDR_XFER_CNT_EN
        .o_xfer_cnt (o_xfer_cnt),
`endif
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        int           t;
    } ent_t;

    logic [W-1:0]     fifo[$];
    ent_t             sb[$];
    int               cyc_n;
    int               npop;
    int               first_rd;
    int               first_vld;
    logic [CNT_W-1:0] cnt_m;
    int               total;
    int               bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model, return
    // at posedge+1 with i_rddata carrying any word strobed this cycle.
    task automatic step(input bit en, input bit rdy, input bit fl, input bit rs, input bit gate);
        ent_t         e;
        logic [W-1:0] w;
        bit           ev, ep, er, got_rd;
        rstn    = rs;
        i_en    = en;
        i_ready = rdy;
        i_flush = fl;
        i_empty = (fifo.size() == 0) || gate;
        @(negedge clk);
        ev = (sb.size() > 0) && (sb[0].t <= cyc_n);
        ep = ev && rdy;
        er = en && !i_empty && !fl && !rs && ((sb.size() - (ep ? 1 : 0)) < 2);
        chk("valid", o_valid, ev);
        chk("rden", o_rden, er);
        chk("busy", o_busy, sb.size() > 0);
        if (i_empty) chk("rden_empty", o_rden, 0);
        if (ev && o_valid) chk("data", o_data, sb[0].w);
`ifdef FIFO_RDR_XFER_CNT_EN
        chk("xfer_cnt", o_xfer_cnt, cnt_m);
`endif
        if (o_rden && first_rd < 0) first_rd = cyc_n;
        if (o_valid && first_vld < 0) first_vld = cyc_n;
        if (ep) begin
            void'(sb.pop_front());
            npop++;
            cnt_m++;
        end
        if (rs) cnt_m = '0;
        if (rs || fl) sb.delete();
        got_rd = 1'b0;
        w      = '0;
        if (er && fifo.size() > 0) begin
            w   = fifo.pop_front();
            e.w = w;
            e.t = cyc_n + 2;
            sb.push_back(e);
            got_rd = 1'b1;
        end
        @(posedge clk);
        #1;
        i_rddata = got_rd ? w : W'($urandom);
        cyc_n++;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        int start;
        int k;
        total     = 0;
        bad       = 0;
        cyc_n     = 0;
        npop      = 0;
        cnt_m     = '0;
        first_rd  = -1;
        first_vld = -1;
        rstn      = 1'b1;
        i_en      = 1'b0;
        i_flush   = 1'b0;
        i_empty   = 1'b1;
        i_ready   = 1'b0;
        i_rddata  = '0;
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_rden", o_rden, 0);

        // preloaded 1,2,3 with en/ready high
        fifo.push_back(W'(1));
        fifo.push_back(W'(2));
        fifo.push_back(W'(3));
        start     = npop;
        first_rd  = -1;
        first_vld = -1;
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
        chk("basic_words", npop - start, 3);
        chk("first_latency", first_vld - first_rd, 2);
        chk("basic_idle", o_busy, 0);

        // backpressure: hold ready low for 5 cycles mid-stream
        fifo.delete();
        for (int i = 0; i < 20; i++) fifo.push_back(W'(32'h100 + i));
        start = npop;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        #2;
        chk("bp_full_valid", o_valid, 1);
        chk("bp_full_rden", o_rden, 0);
        for (int i = 0; i < 30; i++) step(1, 1, 0, 0, 0);
        chk("bp_words", npop - start, 20);

        // flush with one word buffered and one in flight
        fifo.delete();
        for (int i = 0; i < 5; i++) fifo.push_back(W'(32'h200 + i));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        #2;
        chk("flush_valid", o_valid, 0);
        chk("flush_busy", o_busy, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        start = npop;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        chk("flush_rest", npop - start, 3);

        // 1000 random words, i_empty forced on alternate cycles, random ready
        fifo.delete();
        for (int i = 0; i < 1000; i++) fifo.push_back(W'($urandom));
        start = npop;
        k     = 0;
        while ((npop - start) < 1000 && k < 8000) begin
            step(1, bit'($urandom_range(0, 1)), 0, 0, bit'(cyc_n % 2));
            k++;
        end
        chk("rand_words", npop - start, 1000);

        // reset in the middle of an 8-word burst
        fifo.delete();
        for (int i = 0; i < 8; i++) fifo.push_back(W'(32'h300 + i));
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        #2;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_busy", o_busy, 0);
        step(0, 1, 0, 0, 0);

        // 17 pops wrap a 4-bit counter to 1
        fifo.delete();
        do_reset();
        for (int i = 0; i < 17; i++) fifo.push_back(W'(32'h400 + i));
        start = npop;
        k     = 0;
        while ((npop - start) < 17 && k < 100) begin
            step(1, 1, 0, 0, 0);
            k++;
        end
        chk("cnt_pops", npop - start, 17);
`ifdef FIFO_RDR_XFER_CNT_EN
        #2;
        chk("cnt_wrap", o_xfer_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits.
REQ-002 Parameter CNT_W, default 32, transfer-counter width in bits.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 rstn  input  1  synchronous, active-high reset; a sampled value of 1 resets the block.
REQ-005 i_en  input  1  read enable; 0 blocks new FIFO reads, buffered data still drains.
REQ-006 i_flush  input  1  synchronous discard of buffered and in-flight words.
REQ-007 i_empty  input  1  FIFO empty flag.
REQ-008 i_rddata  input  WIDTH  FIFO read data, valid one cycle after o_rden.
REQ-009 o_rden  output  1  FIFO read strobe.
REQ-010 o_valid  output  1  stream word available.
REQ-011 i_ready  input  1  stream consumer accepts the word.
REQ-012 o_data  output  WIDTH  stream word.
REQ-013 o_busy  output  1  high when state is not IDLE.

Function
REQ-014 The FIFO read latency is fixed at 1 cycle: a word pulled by o_rden in cycle N is captured from i_rddata at the clock edge ending cycle N+1.
REQ-015 The internal store is a 2-entry in-order buffer with occupancy occ (0..2) and an in-flight flag pend (1 cycle after any o_rden).
REQ-016 pop = o_valid && i_ready; o_valid = (occ != 0); o_data = head entry, held stable while o_valid && !i_ready.
REQ-017 o_rden = i_en && !i_empty && !i_flush && !rstn && (occ + pend - pop < 2); this is combinational from i_ready, i_empty and i_en.
REQ-018 An arrival and a pop in the same cycle leave occ unchanged, move the head forward and write the new word at the tail.
REQ-019 Buffer overflow is impossible; an arrival with occ==2 and no pop is an assertion failure.
REQ-020 Steady state with i_ready=1 and a non-empty FIFO gives 1 word/cycle; the first o_valid appears 2 cycles after the first o_rden is asserted.
REQ-021 FSM IDLE: occ==0 && pend==0.
REQ-022 FSM STREAM: occ==1, or occ==0 && pend==1.
REQ-023 FSM FULL: occ==2.
REQ-024 The FSM state is the state computed from next-state occ/pend; transitions follow directly from that.
REQ-025 i_flush=1 in cycle N: occ and pend are cleared at the end of cycle N, the cycle-N arrival is dropped, o_rden=0 in cycle N, and the state is IDLE in cycle N+1.
REQ-026 Deasserting i_en while pend=1 still captures the in-flight word.

Reset
REQ-027 With rstn=1 at a clock edge, occ, pend, the counter and the FSM clear, giving state IDLE, o_valid=0, o_busy=0 and o_data=0.
REQ-028 o_rden SHALL be 0 in any cycle where rstn=1.
REQ-029 A reset mid-stream discards all buffered and in-flight data with no partial output.

Configuration
REQ-030 With macro FIFO_RDR_XFER_CNT_EN defined, port o_xfer_cnt (output, CNT_W bits) counts pops, increments by 1 per pop, wraps from all-ones to 0, and is cleared only by reset.
REQ-031 Without FIFO_RDR_XFER_CNT_EN, neither the port nor the counter logic exists and all other behaviour is identical.

Structure
REQ-032 Shared package fifo_pkg holds the WIDTH default, the FSM state enum (IDLE, STREAM, FULL) and the read-latency constant (1).
REQ-033 The 2-entry buffer is sub-module fifo_skid_buf (push, pop, data in/out, occ).
REQ-034 The top level holds the o_rden logic, pend, the FSM and the optional counter.

Verification
REQ-035 Reset, then with the FIFO preloaded with 0x1,0x2,0x3, i_en=1 and i_ready=1 -> o_rden in cycles 0-2, o_valid cycles 2-4 with o_data 0x1,0x2,0x3, then IDLE.
REQ-036 Stream running, i_ready held 0 for 5 cycles -> occ reaches 2 (FULL), o_rden=0, o_data held; on release the words arrive in order with no loss or duplicate.
REQ-037 i_flush asserted in the cycle after o_rden (pend=1, occ=1) -> next cycle o_valid=0, state IDLE, and the dropped word never appears.
REQ-038 i_empty toggling every cycle with i_ready random for 1000 words -> the output sequence equals the FIFO sequence and o_rden is never asserted while i_empty=1.
REQ-039 rstn=1 in the middle of a burst of 8 words -> next cycle o_valid=0, o_busy=0 and o_rden=0.
REQ-040 With FIFO_RDR_XFER_CNT_EN defined and CNT_W=4, 17 pops -> o_xfer_cnt=1.
